uart_rx_8n1: RTL
================

Name: uart_rx_8n1

Overview:
- UART receiver for 8N1 serial frames: 1 start bit, 8 data bits, no parity, 1 stop bit.
- Sits directly upstream of the UART control/test logic. It converts the asynchronous serial pin into a byte plus a one-cycle strobe.
- rx_data/rx_done connect straight to the consumer's uart_rx_data/uart_rx_done inputs, which decode bytes 0x00-0x05 as LED toggle commands.
- Framing errors are flagged separately and never produce rx_done.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD_RATE, 115200: serial bit rate in bit/s.
- Derived BIT_CNT = CLK_FREQ / BAUD_RATE (integer division; 434 at defaults). Derived HALF = BIT_CNT / 2 (217 at defaults).

Ports:
- clk_50m  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- uart_rxd  in  1  serial input pin, asynchronous to clk_50m, idle high.
- rx_data  out  8  last correctly received byte.
- rx_done  out  1  one-cycle pulse: new valid byte on rx_data.
- rx_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- rx_busy  out  1  high while a frame is being received.

Behaviour:
- Reset values:
  - rx_data = 0x00; rx_done, rx_frame_err, rx_busy = 0.
  - Synchroniser flops = 1; edge-history flop = 1.
  - FSM = IDLE; bit and cycle counters = 0.
- Synchronisation and edge detection:
  - uart_rxd passes through a 2-flop synchroniser; its output is rxd_s.
  - Falling edge = rxd_s==0 while previous rxd_s==1. The cycle in which this is detected is called t0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: rx_busy=0. On a falling edge -> START, cycle counter cleared.
  - START: at t0+HALF, sample rxd_s.
    - If 1: false start; return to IDLE with no output pulse.
    - If 0: go to DATA.
  - DATA: data bit i (i=0..7, LSB first) is sampled at t0+HALF+(i+1)*BIT_CNT into a shift register. After bit 7 -> STOP.
  - STOP: stop bit sampled at t0+HALF+9*BIT_CNT.
    - If 1: on the next cycle, rx_data <= shift register and rx_done=1 for exactly one cycle.
    - If 0: on the next cycle, rx_frame_err=1 for one cycle and rx_data is unchanged.
    - In both cases the FSM returns to IDLE on that same cycle.
- rx_busy is 1 from the cycle after t0 through the stop-sample cycle inclusive.
- rx_data holds its value between valid frames.
- Back-to-back frames:
  - The FSM is back in IDLE half a bit before the stop bit ends.
  - The next start edge is therefore accepted with no gap requirement beyond the 1 stop bit.
- Line held low (break or framing error): no retrigger until rxd_s returns to 1 and then falls again, because IDLE requires an edge.
- Edges during START/DATA/STOP are ignored. Only the scheduled sample points matter.
- rx_done and rx_frame_err are never high in the same cycle.
- Reset mid-frame: immediate asynchronous return to reset values. The partial byte is discarded and no pulse is emitted.
- Counters: cycle counter width = clog2(BIT_CNT)+1; wraps to 0 at each bit boundary. Bit counter is 4 bits.
- Tolerance: correct reception for transmitter baud within ±2% of BAUD_RATE.

Test Plan:
- Single byte: defaults; drive frame 0x05 at 115200 with t0 known.
  -> rx_data=0x05 and rx_done high exactly one cycle at t0+217+9*434+1.
  -> rx_busy falls the cycle before; rx_frame_err stays 0.
- Back-to-back: 0x00 then 0xFF then 0xA5, no idle gap.
  -> three rx_done pulses, with rx_data 0x00, 0xFF, 0xA5 in order; no frame errors.
- Glitch rejection: uart_rxd low for 100 cycles, then high.
  -> no rx_done, no rx_frame_err; FSM back in IDLE after t0+217.
- Framing error: receive 0x3C, then send a frame of 0x12 with stop bit 0.
  -> one rx_frame_err pulse; no rx_done; rx_data stays 0x3C.
  -> line kept low 5 bit-times then released, followed by a valid 0x01 -> exactly one rx_done with 0x01.
- Reset mid-frame: assert reset_n low during data bit 4 of 0x7E, release, then send 0x02.
  -> all outputs 0 during reset; only one rx_done, with 0x02.
- Parameter/baud: CLK_FREQ=1_000_000, BAUD_RATE=100_000 (BIT_CNT=10).
  -> 0x5A received with rx_done at t0+5+90+1.
  -> at defaults, a sender at 117504 and one at 112896 bit/s (±2%) each deliver 0xC3 correctly.

Source files
------------

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 UART receiver.
// Two-flop synchronises the serial pin, detects the start edge and samples
// mid-bit from that edge. A good stop bit publishes the byte with a
// one-cycle rx_done. A bad stop bit pulses rx_frame_err and leaves rx_data untouched.
module uart_rx_8n1 #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic       clk_50m,
  input  logic       reset_n,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int unsigned BIT_CNT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF    = BIT_CNT / 2;
  localparam int unsigned CNT_W   = $clog2(BIT_CNT) + 1;

  // Counter values at which a sample is taken. The counter is 0 in the cycle
  // after t0, so value K is reached K+1 cycles after t0.
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_sync1;
  logic             r_rxd_s;
  logic             r_rxd_prev;
  logic             w_fall;

  logic [CNT_W-1:0] r_cyc_cnt;
  logic [CNT_W-1:0] w_cyc_cnt_nxt;
  logic [3:0]       r_bit_cnt;
  logic [3:0]       w_bit_cnt_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic [7:0]       r_data;
  logic [7:0]       w_data_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_frame_err;
  logic             w_frame_err_nxt;

  logic             w_half_tick;
  logic             w_bit_tick;

  // Pin synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1    <= 1'b1;
      r_rxd_s    <= 1'b1;
      r_rxd_prev <= 1'b1;
    end else begin
      r_sync1    <= uart_rxd;
      r_rxd_s    <= r_sync1;
      r_rxd_prev <= r_rxd_s;
    end
  end

  assign w_fall      = r_rxd_prev & ~r_rxd_s;
  assign w_half_tick = (r_cyc_cnt == HALF_LAST);
  assign w_bit_tick  = (r_cyc_cnt == BIT_LAST);

  // FSM state register.
  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath registers: counters, shift register and output pulses.
  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      r_cyc_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_cyc_cnt   <= w_cyc_cnt_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_data      <= w_data_nxt;
      r_done      <= w_done_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  // Next-state and datapath decode. The counter is held at 0 in IDLE, so the
  // frame timebase starts at 0 in the cycle after the start edge. It restarts
  // at every sample point. Edges outside IDLE are ignored.
  always_comb begin
    w_state_nxt     = r_state;
    w_cyc_cnt_nxt   = r_cyc_cnt + CNT_W'(1);
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_data_nxt      = r_data;
    w_done_nxt      = 1'b0;
    w_frame_err_nxt = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_cyc_cnt_nxt = '0;
        w_bit_cnt_nxt = '0;
        if (w_fall) begin
          w_state_nxt = S_START;
        end
      end

      S_START: begin
        if (w_half_tick) begin
          w_cyc_cnt_nxt = '0;
          // High at mid start bit means a glitch: drop it silently.
          w_state_nxt   = r_rxd_s ? S_IDLE : S_DATA;
        end
      end

      S_DATA: begin
        if (w_bit_tick) begin
          w_cyc_cnt_nxt = '0;
          w_shift_nxt   = {r_rxd_s, r_shift[7:1]};
          if (r_bit_cnt == 4'd7) begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = S_STOP;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end
        end
      end

      S_STOP: begin
        if (w_bit_tick) begin
          w_cyc_cnt_nxt = '0;
          w_state_nxt   = S_IDLE;
          if (r_rxd_s) begin
            w_data_nxt = r_shift;
            w_done_nxt = 1'b1;
          end else begin
            w_frame_err_nxt = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign rx_data      = r_data;
  assign rx_done      = r_done;
  assign rx_frame_err = r_frame_err;
  assign rx_busy      = (r_state != S_IDLE);

endmodule
